mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 64, address width; DATA_WIDTH, default 64, data width; TIMEOUT, default 255, maximum BUSY cycles waiting for ack.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_arstn  input  1  reset, asynchronous, active-low.
REQ-004 i_if_req  input  1  instruction-fetch read request; held until o_if_done.
REQ-005 i_if_addr  input  ADDR_WIDTH  fetch address.
REQ-006 o_if_rdata  output  DATA_WIDTH  fetch read data.
REQ-007 o_if_done  output  1  one-cycle fetch completion pulse.
REQ-008 o_if_err  output  1  one-cycle fetch timeout pulse, coincident with o_if_done.
REQ-009 i_dm_req  input  1  data-memory request; held until o_dm_done.
REQ-010 i_dm_we  input  1  1 = write, 0 = read.
REQ-011 i_dm_addr  input  ADDR_WIDTH  data address.
REQ-012 i_dm_wdata  input  DATA_WIDTH  write data.
REQ-013 o_dm_rdata  output  DATA_WIDTH  data read result.
REQ-014 o_dm_done  output  1  one-cycle data completion pulse.
REQ-015 o_dm_err  output  1  one-cycle data timeout pulse, coincident with o_dm_done.
REQ-016 o_mem_req  output  1  shared memory port request; held high until ack or timeout.
REQ-017 o_mem_we  output  1  shared port write enable.
REQ-018 o_mem_addr  output  ADDR_WIDTH  shared port address.
REQ-019 o_mem_wdata  output  DATA_WIDTH  shared port write data.
REQ-020 i_mem_ack  input  1  memory completion; i_mem_rdata valid in same cycle.
REQ-021 i_mem_rdata  input  DATA_WIDTH  memory read data.
REQ-022 o_busy  output  1  high in BUSY and DONE states.

Function
REQ-023 FSM SHALL have states IDLE, BUSY, DONE; IDLE -> BUSY on grant, BUSY -> DONE on ack or timeout, DONE -> IDLE unconditionally.
REQ-024 Requests SHALL be sampled only in IDLE; requests in BUSY/DONE are ignored.
REQ-025 In IDLE with one request, that port SHALL be granted; with both, the port not granted most recently SHALL win (round-robin via last_grant bit).
REQ-026 On grant, we/addr/wdata SHALL be registered (fetch: we=0, wdata=0); o_mem_* SHALL come from these registers and stay constant through BUSY.
REQ-027 o_mem_req SHALL be high exactly in BUSY: request sampled in cycle N -> o_mem_req high from cycle N+1.
REQ-028 i_mem_ack SHALL be ignored outside BUSY.
REQ-029 Ack sampled in BUSY at cycle K -> DONE in cycle K+1: owner's done = 1, err = 0; minimum request-to-done latency 2 cycles.
REQ-030 On a read ack, i_mem_rdata SHALL be captured into the owner's rdata register; a write ack SHALL leave o_dm_rdata unchanged.
REQ-031 o_if_rdata/o_dm_rdata SHALL hold their value until the next read completion on that port.
REQ-032 A wait counter SHALL clear on grant and increment each BUSY cycle without ack; after TIMEOUT such cycles, go to DONE with owner's done = 1 and err = 1, rdata unchanged.
REQ-033 Ack in the same cycle the timeout condition is reached SHALL count as ack (no error).
REQ-034 done/err SHALL be high only in DONE and only for the owning port; the non-owner's done/err stay 0.
REQ-035 A requester still asserting req in the DONE cycle SHALL be treated as a new request at the next IDLE cycle.

Reset
REQ-036 While i_arstn = 0, state SHALL be IDLE, last_grant = IF (data wins first tie), counter = 0, and every output including rdata SHALL be 0.
REQ-037 Reset mid-transaction SHALL drop o_mem_req immediately (asynchronously) with no done/err pulse; the transaction is lost.

Verification
REQ-038 IF read at addr 0x1000, ack 3 cycles after o_mem_req rises with rdata 0xDEAD -> o_if_done one cycle after ack, o_if_rdata = 0xDEAD, o_if_err = 0.
REQ-039 Both requests simultaneously after reset -> DM granted first; after its done, IF granted; the next tie goes to DM.
REQ-040 DM write addr 0x20 data 0x55, ack in first BUSY cycle -> o_mem_we = 1, o_mem_wdata = 0x55, o_dm_done 2 cycles after request, o_dm_rdata unchanged.
REQ-041 TIMEOUT = 4, no ack -> o_mem_req high 4 cycles, then o_dm_done = o_dm_err = 1 for one cycle; ack on the 4th cycle -> no err.
REQ-042 i_arstn low during BUSY -> o_mem_req = 0 immediately, no done pulse; after release, all outputs 0 and a new request is granted normally.
REQ-043 Stray i_mem_ack in IDLE or DONE -> no state change, no done pulse, rdata unchanged.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (fetch, data), the arbiter and the shared memory port.
// Signal names are seen from the arbiter: i_* are driven into it, o_* are driven by it.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  i_if_req;
    logic [ADDR_WIDTH-1:0] i_if_addr;
    logic [DATA_WIDTH-1:0] o_if_rdata;
    logic                  o_if_done;
    logic                  o_if_err;

    logic                  i_dm_req;
    logic                  i_dm_we;
    logic [ADDR_WIDTH-1:0] i_dm_addr;
    logic [DATA_WIDTH-1:0] i_dm_wdata;
    logic [DATA_WIDTH-1:0] o_dm_rdata;
    logic                  o_dm_done;
    logic                  o_dm_err;

    logic                  o_mem_req;
    logic                  o_mem_we;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_wdata;
    logic                  i_mem_ack;
    logic [DATA_WIDTH-1:0] i_mem_rdata;

    logic                  o_busy;

    modport slave (
        input  i_if_req, i_if_addr,
        input  i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata,
        input  i_mem_ack, i_mem_rdata,
        output o_if_rdata, o_if_done, o_if_err,
        output o_dm_rdata, o_dm_done, o_dm_err,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        output o_busy
    );

    modport master (
        output i_if_req, i_if_addr,
        output i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata,
        output i_mem_ack, i_mem_rdata,
        input  o_if_rdata, o_if_done, o_if_err,
        input  o_dm_rdata, o_dm_done, o_dm_err,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        input  o_busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data memory.
//   state  | meaning
//   S_IDLE | sample requests, grant one port and latch its command
//   S_BUSY | o_mem_req high, wait for ack or TIMEOUT cycles
//   S_DONE | one-cycle done (and err on timeout) pulse to the owner
module mem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic          i_clk,
    input  logic          i_arstn,
    mem_arbiter_if.slave  bus
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_dm;
    logic                  r_owner_dm;
    logic                  r_err;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_dm_rdata;
    logic [CW-1:0]         r_wait_cnt;

    logic w_any_req;
    logic w_grant_dm;
    logic w_timeout;

    assign w_any_req  = bus.i_if_req | bus.i_dm_req;
    // On a tie the port that did not win last time goes first.
    assign w_grant_dm = bus.i_dm_req & (~bus.i_if_req | ~r_last_dm);
    assign w_timeout  = (r_wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_nxt = S_BUSY;
            S_BUSY:  if (bus.i_mem_ack || w_timeout) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_last_dm  <= 1'b0;
            r_owner_dm <= 1'b0;
            r_err      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner_dm <= w_grant_dm;
                        r_last_dm  <= w_grant_dm;
                        r_we       <= w_grant_dm & bus.i_dm_we;
                        r_addr     <= w_grant_dm ? bus.i_dm_addr  : bus.i_if_addr;
                        r_wdata    <= w_grant_dm ? bus.i_dm_wdata : '0;
                        r_wait_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    r_err <= ~bus.i_mem_ack & w_timeout;
                    if (bus.i_mem_ack) begin
                        if (!r_we) begin
                            if (r_owner_dm) r_dm_rdata <= bus.i_mem_rdata;
                            else            r_if_rdata <= bus.i_mem_rdata;
                        end
                    end else if (!w_timeout) begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.o_mem_req   = (r_state == S_BUSY);
        bus.o_busy      = (r_state == S_BUSY) || (r_state == S_DONE);
        bus.o_mem_we    = r_we;
        bus.o_mem_addr  = r_addr;
        bus.o_mem_wdata = r_wdata;
        bus.o_if_done   = (r_state == S_DONE) & ~r_owner_dm;
        bus.o_if_err    = (r_state == S_DONE) & ~r_owner_dm & r_err;
        bus.o_dm_done   = (r_state == S_DONE) &  r_owner_dm;
        bus.o_dm_err    = (r_state == S_DONE) &  r_owner_dm & r_err;
        bus.o_if_rdata  = r_if_rdata;
        bus.o_dm_rdata  = r_dm_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Transaction-level bench for mem_arbiter: directed scenarios followed by random traffic,
// compared against a model that tracks pending requests, round-robin winner and read data.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk   = 1'b0;
    logic arstn = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .i_clk   (clk),
        .i_arstn (arstn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // reference model state
    bit          pend_if, pend_dm, last_dm;
    logic [AW-1:0] if_addr, dm_addr;
    logic          dm_we;
    logic [DW-1:0] dm_wdata, exp_if_rd, exp_dm_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        bus.i_if_req   = pend_if;
        bus.i_if_addr  = if_addr;
        bus.i_dm_req   = pend_dm;
        bus.i_dm_we    = dm_we;
        bus.i_dm_addr  = dm_addr;
        bus.i_dm_wdata = dm_wdata;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"}, bus.o_mem_req, 0);
        chk({tag, "_mem_we"}, bus.o_mem_we, 0);
        chk({tag, "_mem_addr"}, bus.o_mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.o_mem_wdata, 0);
        chk({tag, "_dones"}, {bus.o_if_done, bus.o_dm_done, bus.o_if_err, bus.o_dm_err}, 0);
        chk({tag, "_if_rdata"}, bus.o_if_rdata, 0);
        chk({tag, "_dm_rdata"}, bus.o_dm_rdata, 0);
        chk({tag, "_busy"}, bus.o_busy, 0);
    endtask

    task automatic model_reset();
        pend_if   = 1'b0;
        pend_dm   = 1'b0;
        last_dm   = 1'b0;
        exp_if_rd = '0;
        exp_dm_rd = '0;
        drive_reqs();
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        model_reset();
        tick();
        chk_all_zero("rst");
        arstn = 1'b1;
        tick();
    endtask

    // Serve one grant from IDLE; d = BUSY cycles before ack, so ack lands in BUSY cycle d+1.
    task automatic serve(input int d, input logic [DW-1:0] rd, input bit stray);
        bit            own_dm, exp_err;
        int            n;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        own_dm  = pend_dm && (!pend_if || !last_dm);
        last_dm = own_dm;
        e_we    = own_dm ? dm_we : 1'b0;
        e_addr  = own_dm ? dm_addr : if_addr;
        e_wdata = own_dm ? dm_wdata : '0;
        exp_err = (d + 1 > TO);
        n       = exp_err ? TO : d + 1;
        drive_reqs();
        tick();
        for (int k = 1; k <= n; k++) begin
            chk("busy_mem_req", bus.o_mem_req, 1);
            chk("busy_mem_we", bus.o_mem_we, e_we);
            chk("busy_mem_addr", bus.o_mem_addr, e_addr);
            chk("busy_mem_wdata", bus.o_mem_wdata, e_wdata);
            chk("busy_no_done", {bus.o_if_done, bus.o_dm_done}, 0);
            bus.i_mem_ack   = (k == d + 1);
            bus.i_mem_rdata = (k == d + 1) ? rd : DW'($urandom);
            tick();
            bus.i_mem_ack = 1'b0;
        end
        if (!exp_err && !e_we) begin
            if (own_dm) exp_dm_rd = rd;
            else        exp_if_rd = rd;
        end
        chk("done_mem_req", bus.o_mem_req, 0);
        chk("done_busy", bus.o_busy, 1);
        chk("done_if_done", bus.o_if_done, !own_dm);
        chk("done_dm_done", bus.o_dm_done, own_dm);
        chk("done_if_err", bus.o_if_err, !own_dm && exp_err);
        chk("done_dm_err", bus.o_dm_err, own_dm && exp_err);
        chk("done_if_rdata", bus.o_if_rdata, exp_if_rd);
        chk("done_dm_rdata", bus.o_dm_rdata, exp_dm_rd);
        if (own_dm) pend_dm = 1'b0;
        else        pend_if = 1'b0;
        drive_reqs();
        if (stray) begin
            bus.i_mem_ack   = 1'b1;
            bus.i_mem_rdata = ~rd;
        end
        tick();
        bus.i_mem_ack = 1'b0;
        chk("idle_busy", bus.o_busy, 0);
        chk("idle_dones", {bus.o_if_done, bus.o_dm_done, bus.o_if_err, bus.o_dm_err}, 0);
        chk("idle_if_rdata", bus.o_if_rdata, exp_if_rd);
        chk("idle_dm_rdata", bus.o_dm_rdata, exp_dm_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        if_addr = '0; dm_addr = '0; dm_we = 1'b0; dm_wdata = '0;
        bus.i_mem_ack = 1'b0;
        bus.i_mem_rdata = '0;
        model_reset();
        #12;
        chk_all_zero("por");
        do_reset();

        // fetch read, ack on the 4th BUSY cycle
        pend_if = 1'b1; if_addr = 32'h1000;
        serve(3, 32'hDEAD, 1'b0);
        chk("if_read_rdata", bus.o_if_rdata, 32'hDEAD);

        // tie-break after reset: DM, then IF, then DM again
        do_reset();
        pend_if = 1'b1; if_addr = 32'h0100;
        pend_dm = 1'b1; dm_we = 1'b0; dm_addr = 32'h0200; dm_wdata = 32'h0;
        serve(1, 32'h1111, 1'b0);
        chk("tie1_if_still_pending", bus.o_dm_rdata, 32'h1111);
        serve(0, 32'h2222, 1'b0);
        pend_if = 1'b1; if_addr = 32'h0300;
        pend_dm = 1'b1; dm_addr = 32'h0400;
        serve(0, 32'h3333, 1'b0);
        chk("tie2_dm_rdata", bus.o_dm_rdata, 32'h3333);
        serve(0, 32'h4444, 1'b0);

        // DM write, ack in first BUSY cycle
        pend_dm = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h55;
        serve(0, 32'hBADBAD, 1'b0);
        chk("write_keeps_dm_rdata", bus.o_dm_rdata, 32'h3333);

        // timeout with a stray ack in DONE, then ack exactly at the limit
        pend_dm = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        serve(9, 32'h7777, 1'b1);
        pend_dm = 1'b1; dm_addr = 32'h44;
        serve(TO - 1, 32'h8888, 1'b0);

        // reset in the middle of BUSY
        pend_dm = 1'b1; dm_we = 1'b0; dm_addr = 32'h60;
        drive_reqs();
        tick();
        chk("mid_rst_req_before", bus.o_mem_req, 1);
        tick();
        #2;
        arstn = 1'b0;
        #1;
        chk("mid_rst_req_drop", bus.o_mem_req, 0);
        chk("mid_rst_no_done", {bus.o_dm_done, bus.o_dm_err, bus.o_if_done}, 0);
        model_reset();
        tick();
        chk_all_zero("mid_rst");
        arstn = 1'b1;
        tick();
        chk_all_zero("post_rst");
        pend_if = 1'b1; if_addr = 32'h0ABC;
        serve(1, 32'hCAFE, 1'b0);

        // stray ack while idle
        for (int i = 0; i < 2; i++) begin
            bus.i_mem_ack   = 1'b1;
            bus.i_mem_rdata = DW'($urandom);
            tick();
            bus.i_mem_ack = 1'b0;
            chk("stray_idle_busy", bus.o_busy, 0);
            chk("stray_idle_dones", {bus.o_if_done, bus.o_dm_done}, 0);
            chk("stray_idle_if_rdata", bus.o_if_rdata, exp_if_rd);
        end

        // random traffic
        for (int it = 0; it < 60; it++) begin
            if (!pend_if && ($urandom % 2 == 1)) begin
                pend_if = 1'b1;
                if_addr = AW'($urandom);
            end
            if (!pend_dm && ($urandom % 2 == 1)) begin
                pend_dm  = 1'b1;
                dm_we    = 1'($urandom % 2);
                dm_addr  = AW'($urandom);
                dm_wdata = DW'($urandom);
            end
            if (!pend_if && !pend_dm) begin
                drive_reqs();
                tick();
                chk("rand_idle_busy", bus.o_busy, 0);
            end else begin
                serve(int'($urandom_range(0, 6)), DW'($urandom), 1'($urandom % 2));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
